fcl_xnor_accumulator: RTL and testbench
=======================================

# fcl_xnor_accumulator

Binary fully-connected-layer datapath stage that sits directly downstream of the FCL read controller and its weight RAM. Each valid beat it XNORs a weight word against the matching activation word, popcounts the result, and accumulates over BEATS beats. After each neuron's last beat it thresholds the sum into one output bit. After NEURONS neurons it presents the packed output vector and pulses done.

## Interface
- WORD_W, 64, weight/activation word width per beat
- BEATS, 6, beats per neuron (matches read-controller inner count)
- NEURONS, 112, neurons per layer pass (matches read-controller outer count)
- ACC_W, 9, accumulator width; must satisfy 2^ACC_W > BEATS*WORD_W
- IDX_W, 7, neuron index width; must satisfy 2^IDX_W >= NEURONS
- iCLK  in  1  clock; everything is rising-edge
- iRSTn  in  1  asynchronous active-low reset
- iCLR  in  1  synchronous clear; aborts the current pass
- iVALID  in  1  iWEIGHT/iACT hold a valid beat this cycle (weight RAM data, aligned by upstream to one cycle after the address)
- iWEIGHT  in  WORD_W  binary weight word
- iACT  in  WORD_W  binary activation word
- iTHR  in  ACC_W  unsigned threshold for the current neuron; sampled on that neuron's last beat
- oBIT  out  1  thresholded neuron output
- oBIT_VALID  out  1  one-cycle strobe; oBIT and oIDX are valid
- oIDX  out  IDX_W  index of the neuron in oBIT
- oVEC  out  NEURONS  packed outputs; bit i is neuron i
- oDONE  out  1  one-cycle pulse when neuron NEURONS-1 completes

## Operation
- Per-beat popcount: pc = popcount(~(iWEIGHT ^ iACT)), range 0..WORD_W, combinational.
- Registers:
  - acc[ACC_W-1:0]
  - beat counter (0..BEATS-1)
  - neuron counter (0..NEURONS-1)
  - state: IDLE or ACC
- IDLE: reset state, and the state after each neuron completes.
  - iVALID moves to ACC with acc <= pc and beat <= 1.
  - If BEATS==1, the beat is treated as a last beat.
- ACC, iVALID on a non-last beat: acc <= acc + pc, beat++.
- ACC, iVALID on the last beat (beat==BEATS-1):
  - sum = acc + pc, unsigned, no overflow by the parameter rule.
  - Next cycle: oBIT <= (sum >= iTHR), oBIT_VALID <= 1, oIDX <= neuron, oVEC[neuron] <= the same bit.
  - acc <= 0, beat <= 0, state <= IDLE.
  - neuron <= neuron+1, wrapping to 0 after NEURONS-1.
- Gaps: iVALID low holds acc, beat and state unchanged. No timeout.
- Pass end: the bit for neuron NEURONS-1 asserts oDONE in the same cycle as its oBIT_VALID.
  - oVEC holds its value after the pass.
  - oVEC is not cleared at the start of the next pass; each bit is overwritten when its neuron completes.
- iCLR wins over iVALID in the same cycle:
  - acc, beat, neuron and oVEC go to 0, state goes to IDLE.
  - That cycle's beat is discarded.
  - No oBIT_VALID or oDONE is generated on the next cycle.
- Reset (iRSTn low, at any time, including mid-neuron):
  - oBIT=0, oBIT_VALID=0, oIDX=0, oVEC=0, oDONE=0.
  - acc=0, beat=0, neuron=0, state IDLE.
  - The partial neuron is lost.

## Timing
- Latency: last beat at cycle N -> oBIT/oBIT_VALID/oIDX/oVEC update at cycle N+1.
- oBIT_VALID and oDONE are high for exactly one cycle per event.
- oBIT and oIDX hold their values until the next strobe.
- Back-to-back neurons:
  - The next neuron's first beat may arrive at N+1.
  - Sustained throughput is one neuron per BEATS valid cycles.
- A full pass with iVALID continuous takes BEATS*NEURONS cycles (672 at defaults).
  - oDONE comes 1 cycle after the final beat.
- Threshold compare is >= and unsigned: iTHR=0 always yields 1.

## Test plan
- Reset then all-ones: iWEIGHT=iACT=all-ones, 6 continuous beats, iTHR=384.
  - Cycle 7 (one cycle after the 6th beat): oBIT=1, oBIT_VALID=1, oIDX=0.
  - Repeat with iTHR=385: oBIT=0.
- Mismatch count: iWEIGHT=0, iACT with 16 ones per beat (pc=48), 6 beats, sum=288.
  - iTHR=288 gives 1; iTHR=289 gives 0.
- Gaps: the same 6 beats with iVALID low for 3 cycles between beats 2 and 3.
  - Identical sum and result; the strobe comes one cycle after the 6th valid beat.
- Full pass: 672 continuous beats with alternating pass/fail thresholds.
  - 112 strobes with oIDX 0..111.
  - oDONE is coincident with oIDX=111.
  - oVEC = ...0101 alternating pattern.
  - The next beat starts again at oIDX=0.
- iCLR with iVALID high at beat 3 of neuron 5:
  - No strobe follows; oVEC=0.
  - The next 6 beats produce oIDX=0.
- iRSTn asserted mid-neuron 10 (asynchronous, between clock edges):
  - All outputs are 0 immediately.
  - After release, 6 beats produce oIDX=0.

Source files
------------

// File: rtl/fcl_xnor_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : fcl_xnor_accumulator
// Purpose  : Binary fully-connected-layer datapath stage. On each valid beat
//            the weight word is XNORed with the activation word and the result
//            is popcounted. The popcounts of BEATS beats are accumulated, and
//            the sum is compared against a per-neuron threshold to give one
//            output bit. The bits of NEURONS neurons are collected into a
//            packed vector, and oDONE pulses when the last neuron completes.
// Ports    : iCLK        rising-edge clock
//            iRSTn       asynchronous active-low reset
//            iCLR        synchronous clear; aborts the current pass
//            iVALID      iWEIGHT/iACT carry a valid beat this cycle
//            iWEIGHT     binary weight word
//            iACT        binary activation word
//            iTHR        unsigned threshold, sampled on the last beat
//            oBIT        thresholded neuron output
//            oBIT_VALID  one-cycle strobe qualifying oBIT/oIDX
//            oIDX        neuron index belonging to oBIT
//            oVEC        packed outputs, bit i is neuron i
//            oDONE       one-cycle pulse when neuron NEURONS-1 completes
// Revision : 1.0 - initial release
// ============================================================================
module fcl_xnor_accumulator #(
  parameter int WORD_W  = 64,
  parameter int BEATS   = 6,
  parameter int NEURONS = 112,
  parameter int ACC_W   = 9,   // 2**ACC_W must exceed BEATS*WORD_W
  parameter int IDX_W   = 7    // 2**IDX_W must cover NEURONS
) (
  input  logic               iCLK,
  input  logic               iRSTn,
  input  logic               iCLR,
  input  logic               iVALID,
  input  logic [WORD_W-1:0]  iWEIGHT,
  input  logic [WORD_W-1:0]  iACT,
  input  logic [ACC_W-1:0]   iTHR,
  output logic               oBIT,
  output logic               oBIT_VALID,
  output logic [IDX_W-1:0]   oIDX,
  output logic [NEURONS-1:0] oVEC,
  output logic               oDONE
);

  localparam int PC_W   = $clog2(WORD_W + 1);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BEAT_W-1:0] C_LAST_BEAT   = BEAT_W'(BEATS - 1);
  localparam logic [IDX_W-1:0]  C_LAST_NEURON = IDX_W'(NEURONS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  // Number of agreeing bit positions between weight and activation.
  function automatic logic [PC_W-1:0] popcount(input logic [WORD_W-1:0] v);
    logic [PC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < WORD_W; i++) begin
      cnt = cnt + PC_W'(v[i]);
    end
    return cnt;
  endfunction

  state_t              r_state;
  state_t              w_stateNext;
  logic [ACC_W-1:0]    r_acc;
  logic [BEAT_W-1:0]   r_beat;
  logic [IDX_W-1:0]    r_neuron;

  logic                r_bit;
  logic                r_bitValid;
  logic [IDX_W-1:0]    r_idx;
  logic [NEURONS-1:0]  r_vec;
  logic                r_done;

  logic [PC_W-1:0]     w_popcount;
  logic [ACC_W-1:0]    w_accBase;
  logic [ACC_W-1:0]    w_sum;
  logic                w_isLast;
  logic                w_bit;
  logic                w_lastNeuron;

  // The first beat of a neuron arrives in IDLE and starts from zero, so the
  // stale accumulator value is never added in. With BEATS==1 the first beat
  // is also the last one.
  assign w_popcount   = popcount(~(iWEIGHT ^ iACT));
  assign w_accBase    = (r_state == S_IDLE) ? '0 : r_acc;
  assign w_sum        = w_accBase + ACC_W'(w_popcount);
  assign w_isLast     = (r_state == S_IDLE) ? (BEATS == 1) : (r_beat == C_LAST_BEAT);
  assign w_bit        = (w_sum >= iTHR);
  assign w_lastNeuron = (r_neuron == C_LAST_NEURON);

  always_comb begin
    w_stateNext = r_state;
    if (iCLR) begin
      w_stateNext = S_IDLE;
    end else if (iVALID) begin
      w_stateNext = w_isLast ? S_IDLE : S_ACC;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_acc      <= '0;
      r_beat     <= '0;
      r_neuron   <= '0;
      r_bit      <= 1'b0;
      r_bitValid <= 1'b0;
      r_idx      <= '0;
      r_vec      <= '0;
      r_done     <= 1'b0;
    end else begin
      // Strobes are single-cycle; they are re-raised only on a last beat.
      r_bitValid <= 1'b0;
      r_done     <= 1'b0;
      if (iCLR) begin
        r_acc    <= '0;
        r_beat   <= '0;
        r_neuron <= '0;
        r_vec    <= '0;
      end else if (iVALID) begin
        if (w_isLast) begin
          r_bit      <= w_bit;
          r_bitValid <= 1'b1;
          r_idx      <= r_neuron;
          r_done     <= w_lastNeuron;
          for (int i = 0; i < NEURONS; i++) begin
            if (r_neuron == IDX_W'(i)) begin
              r_vec[i] <= w_bit;
            end
          end
          r_acc    <= '0;
          r_beat   <= '0;
          r_neuron <= w_lastNeuron ? '0 : r_neuron + IDX_W'(1);
        end else begin
          r_acc  <= w_sum;
          r_beat <= r_beat + BEAT_W'(1);
        end
      end
    end
  end

  assign oBIT       = r_bit;
  assign oBIT_VALID = r_bitValid;
  assign oIDX       = r_idx;
  assign oVEC       = r_vec;
  assign oDONE      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fcl_xnor_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_fcl_xnor_accumulator
// Purpose  : Directed self-checking bench for fcl_xnor_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fcl_xnor_accumulator;

  localparam int WORD_W  = 64;
  localparam int BEATS   = 6;
  localparam int NEURONS = 112;
  localparam int ACC_W   = 9;
  localparam int IDX_W   = 7;

  localparam logic [WORD_W-1:0] ONES  = {WORD_W{1'b1}};
  localparam logic [WORD_W-1:0] ZEROS = '0;
  localparam logic [WORD_W-1:0] ACT16 = 64'h0000_0000_0000_FFFF;

  logic               iCLK;
  logic               iRSTn;
  logic               iCLR;
  logic               iVALID;
  logic [WORD_W-1:0]  iWEIGHT;
  logic [WORD_W-1:0]  iACT;
  logic [ACC_W-1:0]   iTHR;
  logic               oBIT;
  logic               oBIT_VALID;
  logic [IDX_W-1:0]   oIDX;
  logic [NEURONS-1:0] oVEC;
  logic               oDONE;

  int nChecks = 0;
  int nErrors = 0;
  logic [NEURONS-1:0] expVec;

  fcl_xnor_accumulator #(
    .WORD_W(WORD_W), .BEATS(BEATS), .NEURONS(NEURONS), .ACC_W(ACC_W), .IDX_W(IDX_W)
  ) dut (
    .iCLK(iCLK), .iRSTn(iRSTn), .iCLR(iCLR), .iVALID(iVALID),
    .iWEIGHT(iWEIGHT), .iACT(iACT), .iTHR(iTHR),
    .oBIT(oBIT), .oBIT_VALID(oBIT_VALID), .oIDX(oIDX), .oVEC(oVEC), .oDONE(oDONE)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs then show that edge's result.
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic beat(input logic [WORD_W-1:0] w, input logic [WORD_W-1:0] a,
                      input logic [ACC_W-1:0] thr);
    iVALID  = 1'b1;
    iWEIGHT = w;
    iACT    = a;
    iTHR    = thr;
    tick();
    iVALID  = 1'b0;
  endtask

  task automatic gap();
    iVALID = 1'b0;
    tick();
  endtask

  // Five beats with no strobe, then the sixth beat whose result is checked.
  task automatic neuron(input logic [WORD_W-1:0] w, input logic [WORD_W-1:0] a,
                        input logic [ACC_W-1:0] thr, input logic expBit,
                        input logic [IDX_W-1:0] expIdx, input string tag);
    for (int b = 0; b < BEATS - 1; b++) begin
      beat(w, a, thr);
      chk({tag, "_midvalid"}, 128'(oBIT_VALID), 128'(0));
    end
    beat(w, a, thr);
    chk({tag, "_valid"}, 128'(oBIT_VALID), 128'(1));
    chk({tag, "_bit"},   128'(oBIT),       128'(expBit));
    chk({tag, "_idx"},   128'(oIDX),       128'(expIdx));
  endtask

  initial begin
    iRSTn = 1'b0; iCLR = 1'b0; iVALID = 1'b0;
    iWEIGHT = '0; iACT = '0; iTHR = '0;
    tick(); tick();
    chk("rst_bit",   128'(oBIT),       128'(0));
    chk("rst_valid", 128'(oBIT_VALID), 128'(0));
    chk("rst_idx",   128'(oIDX),       128'(0));
    chk("rst_vec",   128'(oVEC),       128'(0));
    chk("rst_done",  128'(oDONE),      128'(0));
    iRSTn = 1'b1;
    tick();

    // All-ones: sum = 6*64 = 384.
    neuron(ONES, ONES, 9'd384, 1'b1, 7'd0, "ones_thr384");
    gap();
    chk("strobe_one_cycle", 128'(oBIT_VALID), 128'(0));
    chk("bit_holds",        128'(oBIT),       128'(1));
    chk("idx_holds",        128'(oIDX),       128'(0));
    neuron(ONES, ONES, 9'd385, 1'b0, 7'd1, "ones_thr385");

    // 16 mismatches per beat: pc = 48, sum = 288.
    neuron(ZEROS, ACT16, 9'd288, 1'b1, 7'd2, "mis_thr288");
    neuron(ZEROS, ACT16, 9'd289, 1'b0, 7'd3, "mis_thr289");

    // Same beats with a three-cycle gap between beats 2 and 3.
    beat(ZEROS, ACT16, 9'd288);
    beat(ZEROS, ACT16, 9'd288);
    for (int g = 0; g < 3; g++) begin
      gap();
      chk("gap_novalid", 128'(oBIT_VALID), 128'(0));
    end
    for (int b = 0; b < 3; b++) begin
      beat(ZEROS, ACT16, 9'd288);
      chk("gap_midvalid", 128'(oBIT_VALID), 128'(0));
    end
    beat(ZEROS, ACT16, 9'd288);
    chk("gap_valid", 128'(oBIT_VALID), 128'(1));
    chk("gap_bit",   128'(oBIT),       128'(1));
    chk("gap_idx",   128'(oIDX),       128'(4));
    chk("vec_5",     128'(oVEC),       128'(112'h15));

    // Clear with a valid beat at beat 3 of neuron 5.
    beat(ONES, ONES, 9'd0);
    beat(ONES, ONES, 9'd0);
    iCLR = 1'b1;
    beat(ONES, ONES, 9'd0);
    iCLR = 1'b0;
    chk("clr_novalid", 128'(oBIT_VALID), 128'(0));
    chk("clr_nodone",  128'(oDONE),      128'(0));
    chk("clr_vec",     128'(oVEC),       128'(0));
    gap();
    chk("clr_novalid2", 128'(oBIT_VALID), 128'(0));
    neuron(ONES, ONES, 9'd0, 1'b1, 7'd0, "after_clr");
    chk("after_clr_vec", 128'(oVEC), 128'(1));

    // Full pass from neuron 0, alternating pass/fail thresholds.
    iCLR = 1'b1;
    tick();
    iCLR = 1'b0;
    chk("pre_pass_vec", 128'(oVEC), 128'(0));
    for (int n = 0; n < NEURONS; n++) begin
      for (int b = 0; b < BEATS; b++) begin
        beat(ONES, ONES, (n % 2 == 0) ? 9'd384 : 9'd385);
        chk("pass_valid", 128'(oBIT_VALID), 128'(b == BEATS - 1));
        chk("pass_done",  128'(oDONE),      128'((b == BEATS - 1) && (n == NEURONS - 1)));
        if (b == BEATS - 1) begin
          chk("pass_idx", 128'(oIDX), 128'(n));
          chk("pass_bit", 128'(oBIT), 128'(n % 2 == 0));
        end
      end
    end
    for (int i = 0; i < NEURONS; i++) expVec[i] = (i % 2 == 0);
    chk("pass_vec", 128'(oVEC), 128'(expVec));
    gap();
    chk("pass_done_pulse", 128'(oDONE), 128'(0));
    chk("pass_vec_hold",   128'(oVEC),  128'(expVec));
    neuron(ONES, ONES, 9'd0, 1'b1, 7'd0, "wrap");
    chk("wrap_done", 128'(oDONE), 128'(0));
    chk("wrap_vec",  128'(oVEC),  128'(expVec));

    // Move to neuron 10, then reset asynchronously mid-neuron.
    for (int n = 1; n < 10; n++) neuron(ONES, ONES, 9'd0, 1'b1, IDX_W'(n), "fill");
    for (int b = 0; b < 3; b++) beat(ONES, ONES, 9'd0);
    #3;
    iRSTn = 1'b0;
    #1;
    chk("arst_bit",   128'(oBIT),       128'(0));
    chk("arst_valid", 128'(oBIT_VALID), 128'(0));
    chk("arst_idx",   128'(oIDX),       128'(0));
    chk("arst_vec",   128'(oVEC),       128'(0));
    chk("arst_done",  128'(oDONE),      128'(0));
    tick();
    iRSTn = 1'b1;
    tick();
    neuron(ONES, ONES, 9'd0, 1'b1, 7'd0, "post_rst");
    chk("post_rst_vec", 128'(oVEC), 128'(1));

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
